tenv_clockdiv: RTL and testbench
================================

# tenv_clockdiv

Multi-channel programmable clock divider for the test environment, the parametrised successor to the single-output clock launcher. It derives `CHANNELS` independent divided clocks from one reference clock. Each channel has its own per-phase high and low cycle counts, enable, idle level and launch status. A common sync input phase-aligns all running channels. Benches use it to produce the x4 sampling clock and slower related clocks from one source, with cycle-exact, reproducible periods.

## Interface
- `CHANNELS`, 2: number of derived clock channels (1..8).
- `CNT_W`, 8: width of each phase-length field.
- `clk  in  1`: reference clock; all logic on rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `en  in  CHANNELS`: per-channel run enable.
- `init  in  CHANNELS`: per-channel idle output level.
- `time_high  in  CHANNELS*CNT_W`: high-phase length in `clk` cycles; channel i is bits [i*CNT_W +: CNT_W].
- `time_low  in  CHANNELS*CNT_W`: low-phase length in `clk` cycles, packed the same way.
- `sync  in  1`: single-cycle pulse that restarts all enabled channels together.
- `clocks  out  CHANNELS`: derived clocks, registered.
- `rise  out  CHANNELS`: one-cycle strobe in the first cycle of each high phase.
- `launched  out  CHANNELS`: sticky flag, set on the channel's first rise after enable.

## Operation
- Each channel runs a 3-state FSM: IDLE, HIGH, LOW. It has a down-counter of width CNT_W.
- Reset state: IDLE, counter 0, `clocks`=0, `rise`=0, `launched`=0.
- `init` drives the output only after the first post-reset cycle.
- IDLE: `clocks`[i]=`init`[i]. On `en`[i]=1, the channel leaves IDLE. It goes to HIGH if `init`=0 and to LOW if `init`=1, so the first transition is always an edge.
- HIGH: counter loads max(`time_high`,1)-1 on entry and decrements each cycle. At 0 the channel goes to LOW.
- LOW: counter loads max(`time_low`,1)-1 on entry. At 0 the channel goes to HIGH.
- A value of 0 in either field is treated as 1. Period = max(th,1)+max(tl,1) cycles.
- `time_high`/`time_low` are sampled only at phase entry. Changes mid-phase take effect at the next phase boundary and never truncate the current phase.
- `rise`[i]=1 exactly in the cycles where FSM state is HIGH and the previous state was not HIGH.
- `launched`[i] is set together with the first `rise`[i]. It is cleared when `en`[i]=0 or on `rst`.
- `en`[i]=0 in any state: the channel returns to IDLE on the next edge. There is no partial-phase completion.
- `sync`=1: every channel with `en`=1 re-enters its start phase (HIGH if `init`=0, else LOW) with a fresh count. This includes channels already running. Channels with `en`=0 ignore `sync`.
- Precedence: `rst` > `en`=0 > `sync` > normal counting.

## Timing
- All outputs are registered. `en` sampled high at edge n gives the first output change visible after edge n+1.
- `sync` sampled at edge n gives a realigned phase start after edge n+1, identical for all channels.
- `rise` is coincident with the 0→1 edge of `clocks`.
- `rst` asserted mid-phase: all outputs are 0 after the next edge.
- Minimum period is 2 cycles, with th=tl=1.

## Configuration
- `TENV_CLKDIV_LOG_EN` defined: on each channel's 0→1 transition of `launched`, the simulation log prints "%0t [tenv_clockdiv]: Launch clock <i>. Period=<p> clk cycles." Here p is the period latched at launch.
- Macro not defined: no display statements are compiled and behaviour is otherwise identical.

## Structure
- Package `tenv_clock_pkg` holds:
  - the state enum `clkdiv_state_t` {IDLE, HIGH, LOW};
  - the CNT_W default;
  - the function `phase_len(cnt)`, which returns max(cnt,1).
- Sub-module `tenv_clockdiv_ch` implements one channel: FSM, counter, rise and launched logic.
- The top level generates `CHANNELS` instances and handles field slicing and logging.

## Test plan
- Reset then idle: `rst`=1 for 3 cycles, `init`=2'b10, `en`=0 → `clocks`=2'b10 and `rise`=`launched`=0.
- Basic divide: ch0 th=3, tl=5, `init`=0, `en`=1 → `clocks`[0] is high for 3 cycles and low for 5, period 8. `rise` pulses every 8 cycles. `launched` is set on the first rise.
- Zero-length fields: th=0, tl=0 → period 2 and 50% duty. With `init`=1, the first phase is LOW.
- Mid-phase reprogram: th=4→1 written during the second cycle of HIGH → the current high lasts 4 cycles and the next lasts 1.
- Sync alignment: ch0 period 6 and ch1 period 4, both running, `sync` pulse → both enter HIGH on the same edge and both `rise` strobes coincide.
- Disable versus sync: `en`[1]=0 in the same cycle as `sync` → ch1 goes to IDLE at its `init` level, `launched`[1]=0, and ch0 realigns.

Source files
------------

// File: rtl/tenv_clock_pkg.sv
// rtl/tenv_clock_pkg.sv - shared state type, defaults and phase-length helper for tenv_clockdiv
package tenv_clock_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } clkdiv_state_t;

   localparam int CNT_W_DEFAULT = 8;

   // A programmed length of 0 behaves as 1 so a channel can never stall.
   function automatic int unsigned phase_len(input int unsigned cnt);
      return (cnt == 0) ? 32'd1 : cnt;
   endfunction

endpackage

// File: rtl/tenv_clockdiv_ch.sv
// rtl/tenv_clockdiv_ch.sv - one divider channel: IDLE/HIGH/LOW FSM, phase counter, rise and launched
module tenv_clockdiv_ch
   import tenv_clock_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             init,
   input  logic [CNT_W-1:0] time_high,
   input  logic [CNT_W-1:0] time_low,
   input  logic             sync,
   output logic             clock,
   output logic             rise,
   output logic             launched
);

   clkdiv_state_t    state;
   logic [CNT_W-1:0] cnt;
   logic             enter_high;
   logic [CNT_W-1:0] high_load;
   logic [CNT_W-1:0] low_load;

   assign high_load = CNT_W'(phase_len(32'(time_high)) - 32'd1);
   assign low_load  = CNT_W'(phase_len(32'(time_low)) - 32'd1);

   // Outputs are a registered image of the state, so rise and clock edges stay coincident.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         enter_high <= 1'b0;
         clock      <= 1'b0;
         rise       <= 1'b0;
         launched   <= 1'b0;
      end else begin
         case (state)
            IDLE:    clock <= init;
            HIGH:    clock <= 1'b1;
            default: clock <= 1'b0;
         endcase
         rise     <= enter_high;
         launched <= (state == IDLE) ? 1'b0 : (launched | enter_high);

         if (!en) begin
            state      <= IDLE;
            cnt        <= '0;
            enter_high <= 1'b0;
         end else if (sync || state == IDLE) begin
            if (init) begin
               state      <= LOW;
               cnt        <= low_load;
               enter_high <= 1'b0;
            end else begin
               state      <= HIGH;
               cnt        <= high_load;
               enter_high <= (state != HIGH);
            end
         end else if (cnt != '0) begin
            cnt        <= cnt - CNT_W'(1);
            enter_high <= 1'b0;
         end else if (state == HIGH) begin
            state      <= LOW;
            cnt        <= low_load;
            enter_high <= 1'b0;
         end else begin
            state      <= HIGH;
            cnt        <= high_load;
            enter_high <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/tenv_clockdiv.sv
// rtl/tenv_clockdiv.sv - multi-channel programmable clock divider top
// Optional launch logging under TENV_CLKDIV_LOG_EN.
module tenv_clockdiv
   import tenv_clock_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int CNT_W    = CNT_W_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS-1:0]       init,
   input  logic [CHANNELS*CNT_W-1:0] time_high,
   input  logic [CHANNELS*CNT_W-1:0] time_low,
   input  logic                      sync,
   output logic [CHANNELS-1:0]       clocks,
   output logic [CHANNELS-1:0]       rise,
   output logic [CHANNELS-1:0]       launched
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      tenv_clockdiv_ch #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .en        (en[i]),
         .init      (init[i]),
         .time_high (time_high[i*CNT_W +: CNT_W]),
         .time_low  (time_low[i*CNT_W +: CNT_W]),
         .sync      (sync),
         .clock     (clocks[i]),
         .rise      (rise[i]),
         .launched  (launched[i])
      );
   end

`ifdef TENV_CLKDIV_LOG_EN
   logic [CHANNELS-1:0] launched_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         launched_q <= '0;
      end else begin
         launched_q <= launched;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_log
      always_ff @(posedge clk) begin
         if (!rst && launched[i] && !launched_q[i]) begin
            $display("%0t [tenv_clockdiv]: Launch clock %0d. Period=%0d clk cycles.", $time, i,
                     phase_len(32'(time_high[i*CNT_W +: CNT_W])) +
                     phase_len(32'(time_low[i*CNT_W +: CNT_W])));
         end
      end
   end
`else
   // Logging disabled: no simulation-only statements are compiled.
`endif

endmodule

// File: tb/tb_tenv_clockdiv.sv
// tb/tb_tenv_clockdiv.sv - scoreboard bench for tenv_clockdiv
module tb_tenv_clockdiv;

   localparam int CH = 2;
   localparam int W  = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            sync;
   logic [CH-1:0]   en;
   logic [CH-1:0]   init;
   logic [CH*W-1:0] time_high;
   logic [CH*W-1:0] time_low;
   logic [CH-1:0]   clocks;
   logic [CH-1:0]   rise;
   logic [CH-1:0]   launched;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Expected {clock, rise, launched} per sample, one queue per channel.
   logic [2:0] q0[$];
   logic [2:0] q1[$];
   bit         lb[CH];

   tenv_clockdiv #(.CHANNELS(CH), .CNT_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .init      (init),
      .time_high (time_high),
      .time_low  (time_low),
      .sync      (sync),
      .clocks    (clocks),
      .rise      (rise),
      .launched  (launched)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int ch, input int th, input int tl);
      time_high[ch*W +: W] = W'(th);
      time_low[ch*W +: W]  = W'(tl);
   endtask

   task automatic push(input int ch, input logic [2:0] v);
      if (ch == 0) q0.push_back(v);
      else         q1.push_back(v);
   endtask

   task automatic push_idle(input int ch, input logic lvl, input int n);
      lb[ch] = 1'b0;
      for (int k = 0; k < n; k++) push(ch, {lvl, 1'b0, 1'b0});
   endtask

   task automatic push_run(input int ch, input logic hi, input int len);
      for (int k = 0; k < len; k++) begin
         logic r;
         r = hi && (k == 0);
         if (r) lb[ch] = 1'b1;
         push(ch, {hi, r, lb[ch]});
      end
   endtask

   task automatic idle_all();
      en   = '0;
      sync = 1'b0;
      repeat (3) step();
      q0.delete();
      q1.delete();
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      en        = '0;
      init      = 2'b10;
      sync      = 1'b0;
      time_high = '0;
      time_low  = '0;
      repeat (3) step();
      total_cnt++;
      if ({clocks, rise, launched} !== 6'b0)
         $display("FAIL reset_hold: got %b want %b", {clocks, rise, launched}, 6'b0);
      else pass_cnt++;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total_cnt++;
         if (clocks !== 2'b10)
            $display("FAIL reset_idle_clocks cyc %0d: got %b want %b", i, clocks, 2'b10);
         else pass_cnt++;
         total_cnt++;
         if ({rise, launched} !== 4'b0)
            $display("FAIL reset_idle_flags cyc %0d: got %b want %b", i, {rise, launched}, 4'b0);
         else pass_cnt++;
      end
   endtask

   task automatic test_basic_divide();
      logic [2:0] e;
      set_ch(0, 3, 5);
      en = 2'b01;
      push_idle(0, 1'b0, 1);
      for (int p = 0; p < 3; p++) begin
         push_run(0, 1'b1, 3);
         push_run(0, 1'b0, 5);
      end
      push_idle(1, 1'b1, 25);
      for (int i = 0; q0.size() > 0 || q1.size() > 0; i++) begin
         step();
         if (q0.size() > 0) begin
            e = q0.pop_front();
            total_cnt++;
            if ({clocks[0], rise[0], launched[0]} !== e)
               $display("FAIL basic ch0 cyc %0d: got %b want %b", i, {clocks[0], rise[0], launched[0]}, e);
            else pass_cnt++;
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            total_cnt++;
            if ({clocks[1], rise[1], launched[1]} !== e)
               $display("FAIL basic ch1 cyc %0d: got %b want %b", i, {clocks[1], rise[1], launched[1]}, e);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_zero_len();
      logic [2:0] e;
      idle_all();
      set_ch(1, 0, 0);
      en = 2'b10;
      push_idle(1, 1'b1, 1);
      for (int p = 0; p < 5; p++) begin
         push_run(1, 1'b0, 1);
         push_run(1, 1'b1, 1);
      end
      push_idle(0, 1'b0, 11);
      for (int i = 0; q0.size() > 0 || q1.size() > 0; i++) begin
         step();
         if (q0.size() > 0) begin
            e = q0.pop_front();
            total_cnt++;
            if ({clocks[0], rise[0], launched[0]} !== e)
               $display("FAIL zero_len ch0 cyc %0d: got %b want %b", i, {clocks[0], rise[0], launched[0]}, e);
            else pass_cnt++;
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            total_cnt++;
            if ({clocks[1], rise[1], launched[1]} !== e)
               $display("FAIL zero_len ch1 cyc %0d: got %b want %b", i, {clocks[1], rise[1], launched[1]}, e);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reprogram();
      logic [2:0] e;
      idle_all();
      set_ch(0, 4, 3);
      en = 2'b01;
      push_idle(0, 1'b0, 1);
      push_run(0, 1'b1, 4);
      push_run(0, 1'b0, 3);
      push_run(0, 1'b1, 1);
      push_run(0, 1'b0, 3);
      push_run(0, 1'b1, 1);
      push_run(0, 1'b0, 3);
      push_idle(1, 1'b1, 16);
      for (int i = 0; q0.size() > 0 || q1.size() > 0; i++) begin
         step();
         if (q0.size() > 0) begin
            e = q0.pop_front();
            total_cnt++;
            if ({clocks[0], rise[0], launched[0]} !== e)
               $display("FAIL reprogram ch0 cyc %0d: got %b want %b", i, {clocks[0], rise[0], launched[0]}, e);
            else pass_cnt++;
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            total_cnt++;
            if ({clocks[1], rise[1], launched[1]} !== e)
               $display("FAIL reprogram ch1 cyc %0d: got %b want %b", i, {clocks[1], rise[1], launched[1]}, e);
            else pass_cnt++;
         end
         if (i == 1) set_ch(0, 1, 3);
      end
   endtask

   task automatic test_sync_align();
      logic [2:0] e;
      init = 2'b00;
      idle_all();
      set_ch(0, 3, 3);
      set_ch(1, 2, 2);
      en = 2'b11;
      push_idle(0, 1'b0, 1);
      push_run(0, 1'b1, 3); push_run(0, 1'b0, 3); push_run(0, 1'b1, 3); push_run(0, 1'b0, 2);
      push_run(0, 1'b1, 3); push_run(0, 1'b0, 3); push_run(0, 1'b1, 3); push_run(0, 1'b0, 3);
      push_idle(1, 1'b0, 1);
      push_run(1, 1'b1, 2); push_run(1, 1'b0, 2); push_run(1, 1'b1, 2);
      push_run(1, 1'b0, 2); push_run(1, 1'b1, 2); push_run(1, 1'b0, 1);
      push_run(1, 1'b1, 2); push_run(1, 1'b0, 2); push_run(1, 1'b1, 2);
      push_run(1, 1'b0, 2); push_run(1, 1'b1, 2); push_run(1, 1'b0, 2);
      for (int i = 0; q0.size() > 0 || q1.size() > 0; i++) begin
         step();
         if (q0.size() > 0) begin
            e = q0.pop_front();
            total_cnt++;
            if ({clocks[0], rise[0], launched[0]} !== e)
               $display("FAIL sync ch0 cyc %0d: got %b want %b", i, {clocks[0], rise[0], launched[0]}, e);
            else pass_cnt++;
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            total_cnt++;
            if ({clocks[1], rise[1], launched[1]} !== e)
               $display("FAIL sync ch1 cyc %0d: got %b want %b", i, {clocks[1], rise[1], launched[1]}, e);
            else pass_cnt++;
         end
         if (i == 10) sync = 1'b1;
         if (i == 11) sync = 1'b0;
      end
   endtask

   task automatic test_disable_vs_sync();
      logic [2:0] e;
      init = 2'b10;
      idle_all();
      set_ch(0, 3, 3);
      set_ch(1, 2, 2);
      en = 2'b11;
      push_idle(0, 1'b0, 1);
      push_run(0, 1'b1, 3); push_run(0, 1'b0, 2);
      push_run(0, 1'b1, 3); push_run(0, 1'b0, 3); push_run(0, 1'b1, 3);
      push_idle(1, 1'b1, 1);
      push_run(1, 1'b0, 2); push_run(1, 1'b1, 2); push_run(1, 1'b0, 1);
      push_idle(1, 1'b1, 9);
      for (int i = 0; q0.size() > 0 || q1.size() > 0; i++) begin
         step();
         if (q0.size() > 0) begin
            e = q0.pop_front();
            total_cnt++;
            if ({clocks[0], rise[0], launched[0]} !== e)
               $display("FAIL dis_sync ch0 cyc %0d: got %b want %b", i, {clocks[0], rise[0], launched[0]}, e);
            else pass_cnt++;
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            total_cnt++;
            if ({clocks[1], rise[1], launched[1]} !== e)
               $display("FAIL dis_sync ch1 cyc %0d: got %b want %b", i, {clocks[1], rise[1], launched[1]}, e);
            else pass_cnt++;
         end
         if (i == 4) begin
            en   = 2'b01;
            sync = 1'b1;
         end
         if (i == 5) sync = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      total_cnt++;
      if (launched[0] !== 1'b1)
         $display("FAIL mid_pre_launched: got %b want %b", launched[0], 1'b1);
      else pass_cnt++;
      rst = 1'b1;
      step();
      total_cnt++;
      if ({clocks, rise, launched} !== 6'b0)
         $display("FAIL mid_reset: got %b want %b", {clocks, rise, launched}, 6'b0);
      else pass_cnt++;
      rst = 1'b0;
      en  = '0;
      step();
   endtask

   initial begin
      test_reset();
      test_basic_divide();
      test_zero_len();
      test_reprogram();
      test_sync_align();
      test_disable_vs_sync();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
